// File: rtl/priority_resolver_n_if.sv
// Request/command/result bundle between the IRR/ISR/IMR + OCW2 side and the priority resolver.
interface priority_resolver_n_if #(
   parameter int NUM_IRQ = 8,
   parameter int IDX_W   = 3
);
   logic               freeze;
   logic [NUM_IRQ-1:0] irr;
   logic [NUM_IRQ-1:0] isr;
   logic [NUM_IRQ-1:0] imr;
   logic               special_mask;
   logic               cmd_valid;
   logic [2:0]         cmd;
   logic [IDX_W-1:0]   cmd_level;
   logic               int_ack;
   logic               int_req;
   logic [IDX_W-1:0]   int_index;
   logic [IDX_W-1:0]   base;

   modport master (
      output freeze, irr, isr, imr, special_mask, cmd_valid, cmd, cmd_level, int_ack,
      input  int_req, int_index, base
   );

   modport slave (
      input  freeze, irr, isr, imr, special_mask, cmd_valid, cmd, cmd_level, int_ack,
      output int_req, int_index, base
   );
endinterface

// File: rtl/priority_resolver_n.sv
// Rotating-priority interrupt resolver: scans candidates and in-service bits from base,
// registers the request/index, and applies OCW2 rotation commands and auto-rotate on ack.
module priority_resolver_n #(
   parameter int NUM_IRQ = 8,
   parameter int IDX_W   = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   priority_resolver_n_if.slave  bus
);

   localparam logic [2:0] CMD_AUTO_CLR = 3'b000;
   localparam logic [2:0] CMD_AUTO_SET = 3'b100;
   localparam logic [2:0] CMD_ROT_NS   = 3'b101;
   localparam logic [2:0] CMD_SET_PRI  = 3'b110;
   localparam logic [2:0] CMD_ROT_S    = 3'b111;

   logic               int_req_q,   int_req_d;
   logic [IDX_W-1:0]   int_index_q, int_index_d;
   logic [IDX_W-1:0]   base_q,      base_d;
   logic               auto_rot_q,  auto_rot_d;

   logic [NUM_IRQ-1:0] cand;
   logic [IDX_W-1:0]   scan_idx;
   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic               hi_found;
   logic [IDX_W-1:0]   hi_idx;
   logic [IDX_W-1:0]   win_off;
   logic [IDX_W-1:0]   hi_off;
   logic               fire;
   logic               cmd_rot;

   always_comb begin
      cand      = bus.irr & ~bus.imr;
      if (bus.special_mask) begin
         cand = cand & ~bus.isr;
      end
      scan_idx  = '0;
      win_found = 1'b0;
      win_idx   = '0;
      hi_found  = 1'b0;
      hi_idx    = '0;
      // Walk channels in priority order starting at base; index math wraps at IDX_W bits.
      for (int i = 0; i < NUM_IRQ; i++) begin
         scan_idx = base_q + IDX_W'(i);
         if (!win_found && cand[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
         if (!hi_found && bus.isr[scan_idx]) begin
            hi_found = 1'b1;
            hi_idx   = scan_idx;
         end
      end
      win_off = win_idx - base_q;
      hi_off  = hi_idx - base_q;
      fire    = win_found && (bus.special_mask || !hi_found || (win_off < hi_off));
   end

   always_comb begin
      int_req_d   = int_req_q;
      int_index_d = int_index_q;
      base_d      = base_q;
      auto_rot_d  = auto_rot_q;
      cmd_rot     = 1'b0;

      if (!bus.freeze) begin
         int_req_d = fire;
         if (fire) begin
            int_index_d = win_idx;
         end
      end

      if (bus.cmd_valid) begin
         case (bus.cmd)
            CMD_ROT_NS: begin
               cmd_rot = 1'b1;
               if (hi_found) begin
                  base_d = hi_idx + IDX_W'(1);
               end
            end
            CMD_ROT_S, CMD_SET_PRI: begin
               cmd_rot = 1'b1;
               base_d  = bus.cmd_level + IDX_W'(1);
            end
            CMD_AUTO_SET: auto_rot_d = 1'b1;
            CMD_AUTO_CLR: auto_rot_d = 1'b0;
            default: ;
         endcase
      end

      // A base-changing command in the same cycle takes precedence over ack rotation.
      if (!cmd_rot && auto_rot_q && bus.int_ack) begin
         base_d = int_index_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         int_req_q   <= 1'b0;
         int_index_q <= '0;
         base_q      <= '0;
         auto_rot_q  <= 1'b0;
      end else begin
         int_req_q   <= int_req_d;
         int_index_q <= int_index_d;
         base_q      <= base_d;
         auto_rot_q  <= auto_rot_d;
      end
   end

   assign bus.int_req   = int_req_q;
   assign bus.int_index = int_index_q;
   assign bus.base      = base_q;

endmodule

// File: tb/tb_priority_resolver_n.sv
// Directed bench for priority_resolver_n with hand-computed expectations.
module tb_priority_resolver_n;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   priority_resolver_n_if #(.NUM_IRQ(8), .IDX_W(3)) bus ();

   priority_resolver_n #(.NUM_IRQ(8), .IDX_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmd_pulse(input logic [2:0] code, input logic [2:0] level);
      bus.cmd_valid = 1'b1;
      bus.cmd       = code;
      bus.cmd_level = level;
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd       = 3'b010;
      bus.cmd_level = 3'd0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      bus.freeze       = 1'b0;
      bus.irr          = 8'h00;
      bus.isr          = 8'h00;
      bus.imr          = 8'h00;
      bus.special_mask = 1'b0;
      bus.cmd_valid    = 1'b0;
      bus.cmd          = 3'b010;
      bus.cmd_level    = 3'd0;
      bus.int_ack      = 1'b0;
      tick();
      tick();
      check("reset_req",   32'(bus.int_req),   32'd0);
      check("reset_index", 32'(bus.int_index), 32'd0);
      check("reset_base",  32'(bus.base),      32'd0);
      reset = 1'b0;

      // Fully nested
      bus.irr = 8'h28;
      tick();
      check("fn_req",   32'(bus.int_req),   32'd1);
      check("fn_index", 32'(bus.int_index), 32'd3);
      bus.isr = 8'h08;
      bus.irr = 8'h20;
      tick();
      check("fn_blocked_req",   32'(bus.int_req),   32'd0);
      check("fn_blocked_index", 32'(bus.int_index), 32'd3);
      bus.irr = 8'h04;
      tick();
      check("fn_nest_req",   32'(bus.int_req),   32'd1);
      check("fn_nest_index", 32'(bus.int_index), 32'd2);

      // Masking and special mask
      bus.isr = 8'h00;
      bus.irr = 8'h0C;
      bus.imr = 8'h04;
      tick();
      check("mask_req",   32'(bus.int_req),   32'd1);
      check("mask_index", 32'(bus.int_index), 32'd3);
      bus.isr = 8'h01;
      tick();
      check("mask_isr_block", 32'(bus.int_req), 32'd0);
      bus.special_mask = 1'b1;
      tick();
      check("smm_req",   32'(bus.int_req),   32'd1);
      check("smm_index", 32'(bus.int_index), 32'd3);
      bus.special_mask = 1'b0;
      bus.imr = 8'h00;

      // Rotate on non-specific EOI
      bus.irr = 8'h00;
      bus.isr = 8'h10;
      cmd_pulse(3'b101, 3'd0);
      check("rot_ns_base", 32'(bus.base), 32'd5);
      bus.isr = 8'h00;
      bus.irr = 8'h11;
      tick();
      check("rot_ns_index", 32'(bus.int_index), 32'd0);
      check("rot_ns_req",   32'(bus.int_req),   32'd1);

      // Set priority with wrap, then specific rotate
      cmd_pulse(3'b110, 3'd7);
      check("setpri_wrap_base", 32'(bus.base), 32'd0);
      cmd_pulse(3'b111, 3'd2);
      check("rot_s_base", 32'(bus.base), 32'd3);
      bus.irr = 8'h06;
      tick();
      check("rot_s_index", 32'(bus.int_index), 32'd1);

      // Auto rotation on ack
      cmd_pulse(3'b110, 3'd7);
      cmd_pulse(3'b100, 3'd0);
      bus.irr = 8'h81;
      tick();
      check("auto_index0", 32'(bus.int_index), 32'd0);
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
      check("auto_base1", 32'(bus.base), 32'd1);
      bus.int_ack = 1'b1;
      cmd_pulse(3'b110, 3'd4);
      bus.int_ack = 1'b0;
      check("cmd_beats_ack", 32'(bus.base), 32'd5);
      tick();
      check("auto_index7", 32'(bus.int_index), 32'd7);
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
      check("auto_wrap_base", 32'(bus.base), 32'd0);
      cmd_pulse(3'b000, 3'd0);
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
      check("auto_off_base", 32'(bus.base), 32'd0);

      // Freeze holds outputs while commands still apply; async reset
      bus.irr = 8'h02;
      tick();
      check("frz_pre_index", 32'(bus.int_index), 32'd1);
      bus.freeze = 1'b1;
      bus.irr    = 8'h01;
      tick();
      check("frz_index", 32'(bus.int_index), 32'd1);
      check("frz_req",   32'(bus.int_req),   32'd1);
      bus.irr = 8'h00;
      cmd_pulse(3'b110, 3'd2);
      check("frz_req_hold", 32'(bus.int_req), 32'd1);
      check("frz_cmd_base", 32'(bus.base),    32'd3);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_req",   32'(bus.int_req),   32'd0);
      check("async_rst_base",  32'(bus.base),      32'd0);
      check("async_rst_index", 32'(bus.int_index), 32'd0);
      bus.freeze = 1'b0;
      tick();
      reset = 1'b0;

      // Auto-rotate cleared by reset: ack must not move base
      bus.irr = 8'h04;
      tick();
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
      check("rst_auto_off_base", 32'(bus.base),      32'd0);
      check("rst_post_index",    32'(bus.int_index), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
